// File: rtl/fetch_pkg.sv
// Shared constants and sizing helpers for the instruction-fetch front end.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package fetch_pkg;

  // Every instruction is one 32-bit word; the PC advances by this many bytes.
  localparam int unsigned INSTR_BYTES = 4;

  // Low PC bits that must be zero for a word-aligned fetch address.
  localparam logic [1:0] PC_ALIGN_LO_MASK = 2'b11;

  // Width needed to hold an entry count from 0 up to and including depth.
  function automatic int unsigned occ_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: instruction-memory request/response, decode handshake, redirect.
// Latency: wires only.
// Backpressure: imem_ready throttles requests, dec_ready stalls the decode side.
interface fetch_queue_if #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned DEPTH   = 4
);
  import fetch_pkg::*;

  localparam int unsigned OCC_W = occ_w(DEPTH);

  // Instruction memory side
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ready;
  logic               imem_rvalid;
  logic [INSTR_W-1:0] imem_rdata;

  // Decode side
  logic               dec_valid;
  logic               dec_ready;
  logic [INSTR_W-1:0] dec_instr;
  logic [ADDR_W-1:0]  dec_pc_plus4;

  // Control-flow redirect from decode
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;

  // Status
  logic [OCC_W-1:0]   occupancy;

  // The fetch front end drives requests and the decode head.
  modport master (
    output imem_req, imem_addr, dec_valid, dec_instr, dec_pc_plus4, occupancy,
    input  imem_ready, imem_rvalid, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

  // Memory model and decode stage on the other side.
  modport slave (
    input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc_plus4, occupancy,
    output imem_ready, imem_rvalid, imem_rdata, dec_ready, redirect_valid, redirect_pc
  );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with flush; head is read straight from storage.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must never push when full or pop when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [occ_w(DEPTH)-1:0]  count,
  output logic [WIDTH-1:0]         head_dat
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = occ_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointer/count/storage update; flush discards everything without writing.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_dat;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are meaningless while count is zero, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count    = count_q;
  assign head_dat = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, one-outstanding-request memory interface, prefetch queue and redirect flush.
// Latency: accept->decode 2 cycles; 1 cycle with FETCHQ_BYPASS_EN (empty-queue bypass).
// Backpressure: requests stop once queued + in-flight words reach DEPTH; dec_ready=0 holds head.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic          Clk,
  input  logic          Reset,
  fetch_queue_if.master bus
);

  localparam int unsigned OCC_W   = occ_w(DEPTH);
  localparam int unsigned CRED_W  = OCC_W + 1;
  localparam int unsigned ENTRY_W = INSTR_W + ADDR_W;
  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(INSTR_BYTES);

  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  issue_pc_q, issue_pc_d;
  logic               inflight_q, inflight_d;

  logic [OCC_W-1:0]   fifo_count;
  logic [ENTRY_W-1:0] fifo_head;
  logic               fifo_push;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] rsp_entry;

  logic [CRED_W-1:0]  credit_used;
  logic               accept;
  logic               rsp_take;
  logic [ADDR_W-1:0]  redirect_aligned;

  // Request credit: a word either queued or still in flight holds one slot.
  always_comb begin
    credit_used      = CRED_W'(fifo_count) + CRED_W'(inflight_q);
    bus.imem_req     = !Reset && !bus.redirect_valid && (credit_used < CRED_W'(DEPTH));
    bus.imem_addr    = pc_q;
    accept           = bus.imem_req && bus.imem_ready;
    rsp_take         = bus.imem_rvalid && inflight_q && !bus.redirect_valid;
    rsp_entry        = {bus.imem_rdata, issue_pc_q + PC_INC};
    redirect_aligned = bus.redirect_pc & ~ADDR_W'(PC_ALIGN_LO_MASK);
  end

`ifdef FETCHQ_BYPASS_EN
  logic bypass_hit;

  // Decode head with empty-queue bypass: an arriving word is offered in the same cycle.
  always_comb begin
    bypass_hit    = rsp_take && (fifo_count == '0);
    bus.dec_valid = ((fifo_count != '0) || bypass_hit) && !bus.redirect_valid;
    if (bypass_hit) begin
      bus.dec_instr    = rsp_entry[ENTRY_W-1:ADDR_W];
      bus.dec_pc_plus4 = rsp_entry[ADDR_W-1:0];
    end else begin
      bus.dec_instr    = fifo_head[ENTRY_W-1:ADDR_W];
      bus.dec_pc_plus4 = fifo_head[ADDR_W-1:0];
    end
    // A bypassed word that decode takes immediately never touches the queue.
    fifo_pop  = bus.dec_valid && bus.dec_ready && (fifo_count != '0);
    fifo_push = rsp_take && !(bypass_hit && bus.dec_ready);
  end
`else
  // Decode head straight from queue storage; no path from imem_rdata to decode.
  always_comb begin
    bus.dec_valid    = (fifo_count != '0) && !bus.redirect_valid;
    bus.dec_instr    = fifo_head[ENTRY_W-1:ADDR_W];
    bus.dec_pc_plus4 = fifo_head[ADDR_W-1:0];
    fifo_pop         = bus.dec_valid && bus.dec_ready;
    fifo_push        = rsp_take;
  end
`endif

  // Next fetch PC, in-flight flag and the PC of the outstanding request.
  always_comb begin
    pc_d       = pc_q;
    issue_pc_d = issue_pc_q;
    inflight_d = accept;
    if (bus.redirect_valid) begin
      pc_d = redirect_aligned;
    end else if (accept) begin
      pc_d = pc_q + PC_INC;
    end
    if (accept) begin
      issue_pc_d = pc_q;
    end
  end

  // Fetch state register; Reset dominates redirect.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      pc_q       <= RESET_PC;
      issue_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (Clk),
    .rst      (Reset),
    .flush    (bus.redirect_valid),
    .push     (fifo_push),
    .push_dat (rsp_entry),
    .pop      (fifo_pop),
    .count    (fifo_count),
    .head_dat (fifo_head)
  );

  assign bus.occupancy = fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: cycle table plus reset, redirect and wrap sequences.
// Latency: memory model answers one cycle after each accepted request, data = address.
// Backpressure: dec_ready/imem_ready driven from the vectors.
module tb_fetch_queue;

  localparam int unsigned AW  = 32;
  localparam int unsigned IW  = 32;
  localparam int unsigned DP  = 4;
  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        Clk   = 1'b0;
  logic        Reset = 1'b1;
  int          n_cmp  = 0;
  int          n_err  = 0;
  int          n_viol = 0;
  logic        pend_acc;
  logic [31:0] pend_addr;
  logic [31:0] exp_next;

  fetch_queue_if #(.ADDR_W(AW), .INSTR_W(IW), .DEPTH(DP)) bus ();

  fetch_queue #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DP),
    .RESET_PC (RPC)
  ) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  // Credit rule: never more than DEPTH entries, never a request while full.
  always @(negedge Clk) begin
    if (Reset === 1'b0) begin
      if (bus.occupancy > DP || (bus.occupancy == DP && bus.imem_req === 1'b1)) n_viol++;
    end
  end

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        drdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ereq;
    logic [31:0] eaddr;
    logic        edv;
    logic [31:0] epc4;
    logic [31:0] eocc;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic rdy, input logic drdy,
                       input logic redir, input logic [31:0] rpc);
    Reset              = rst;
    bus.imem_ready     = rdy;
    bus.dec_ready      = drdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = rpc;
    #1;
  endtask

  // Scoreboard pops, track expected stream, advance one clock, answer accepted requests.
  task automatic cycle();
    #1;
    pend_acc  = (bus.imem_req === 1'b1) && (bus.imem_ready === 1'b1);
    pend_addr = bus.imem_addr;
    if (Reset === 1'b0 && bus.dec_valid === 1'b1 && bus.dec_ready === 1'b1) begin
      chk("pop_instr", bus.dec_instr, exp_next);
      chk("pop_pc_plus4", bus.dec_pc_plus4, exp_next + 32'd4);
      exp_next = exp_next + 32'd4;
    end
    if (Reset === 1'b1) exp_next = RPC;
    else if (bus.redirect_valid === 1'b1) exp_next = bus.redirect_pc & 32'hFFFF_FFFC;
    @(posedge Clk);
    #1;
    bus.imem_rvalid = pend_acc;
    bus.imem_rdata  = pend_addr;
  endtask

  initial begin
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = '0;
    exp_next        = RPC;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    cycle();

`ifndef FETCHQ_BYPASS_EN
    //            rst   rdy   drdy  redir rpc            req   addr           dv    pc4            occ
    vecs.push_back('{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0040_0000, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0000, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0004, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0008, 1'b1, 32'h0040_0004, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_000C, 1'b1, 32'h0040_0008, 32'd1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_0010, 1'b1, 32'h0040_0008, 32'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0040_0014, 1'b1, 32'h0040_0008, 32'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0040_0014, 1'b1, 32'h0040_0008, 32'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0040_0014, 1'b1, 32'h0040_0008, 32'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0040_0014, 1'b1, 32'h0040_0008, 32'd4});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0014, 1'b1, 32'h0040_000C, 32'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0040_0018, 1'b1, 32'h0040_0010, 32'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h0040_001C, 1'b1, 32'h0040_0014, 32'd2});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0103, 1'b0, 32'h0040_0020, 1'b0, 32'h0,         32'd3});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0100, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0104, 1'b1, 32'h0000_0104, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_0108, 1'b1, 32'h0000_0108, 32'd1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_010C, 1'b0, 32'h0,         32'd0});
    vecs.push_back('{1'b0, 1'b1, 1'b1, 1'b0, 32'h0,        1'b1, 32'h0000_010C, 1'b1, 32'h0000_010C, 32'd1});

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].rdy, vecs[i].drdy, vecs[i].redir, vecs[i].rpc);
      chk($sformatf("v%0d_imem_req", i), 32'(bus.imem_req), 32'(vecs[i].ereq));
      chk($sformatf("v%0d_imem_addr", i), bus.imem_addr, vecs[i].eaddr);
      chk($sformatf("v%0d_dec_valid", i), 32'(bus.dec_valid), 32'(vecs[i].edv));
      if (vecs[i].edv) chk($sformatf("v%0d_dec_pc_plus4", i), bus.dec_pc_plus4, vecs[i].epc4);
      chk($sformatf("v%0d_occupancy", i), 32'(bus.occupancy), vecs[i].eocc);
      cycle();
    end
`else
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("byp_reset_occ", 32'(bus.occupancy), 32'd0);
    cycle();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      chk($sformatf("byp_addr%0d", i), bus.imem_addr, RPC + 32'(4 * i));
      cycle();
    end
`endif

    // Reset mid-stream; a stray response the cycle after reset must be ignored.
    drive(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_req_low", 32'(bus.imem_req), 32'd0);
    cycle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'hDEAD_BEEF;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("rst_occ", 32'(bus.occupancy), 32'd0);
    chk("rst_dec_valid", 32'(bus.dec_valid), 32'd0);
    chk("rst_req", 32'(bus.imem_req), 32'd1);
    chk("rst_addr", bus.imem_addr, RPC);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_stray_dropped", 32'(bus.occupancy), 32'd0);
    chk("rst_dv_after", 32'(bus.dec_valid), 32'd0);
    chk("rst_restart_addr", bus.imem_addr, RPC);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("rst_next_addr", bus.imem_addr, RPC + 32'd4);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
      cycle();
    end

    // Fetch-to-decode latency from an empty queue.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0202);
    chk("lat_redir_dv", 32'(bus.dec_valid), 32'd0);
    chk("lat_redir_req", 32'(bus.imem_req), 32'd0);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_first_addr", bus.imem_addr, 32'h0000_0200);
    chk("lat_accept_dv", 32'(bus.dec_valid), 32'd0);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
`ifdef FETCHQ_BYPASS_EN
    chk("lat_plus1_dv", 32'(bus.dec_valid), 32'd1);
    chk("lat_plus1_pc4", bus.dec_pc_plus4, 32'h0000_0204);
`else
    chk("lat_plus1_dv", 32'(bus.dec_valid), 32'd0);
`endif
    chk("lat_plus1_addr", bus.imem_addr, 32'h0000_0204);
    cycle();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    chk("lat_plus2_dv", 32'(bus.dec_valid), 32'd1);
    cycle();

    // Redirect to the top word, stray response after redirect, then PC wrap.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    cycle();
    bus.imem_rvalid = 1'b1;
    bus.imem_rdata  = 32'h0BAD_0BAD;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    chk("wrap_occ0", 32'(bus.occupancy), 32'd0);
    chk("wrap_dv0", 32'(bus.dec_valid), 32'd0);
    chk("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_stray_dropped", 32'(bus.occupancy), 32'd0);
    chk("wrap_req", 32'(bus.imem_req), 32'd1);
    cycle();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    chk("wrap_addr_zero", bus.imem_addr, 32'h0000_0000);
    cycle();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("wrap_dv", 32'(bus.dec_valid), 32'd1);
    chk("wrap_instr", bus.dec_instr, 32'hFFFF_FFFC);
    chk("wrap_pc_plus4", bus.dec_pc_plus4, 32'h0000_0000);
    chk("wrap_occ1", 32'(bus.occupancy), 32'd1);
    cycle();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      cycle();
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    chk("drain_occ", 32'(bus.occupancy), 32'd0);

    chk("credit_violations", 32'(n_viol), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
